// File: rtl/flash_controller.sv
// Bus slave sequencing an x16 parallel NOR flash: 32-bit reads as two halfword
// accesses, raw 16-bit write cycles, and an automatic read-array command after reset.
package flash_controller_pkg;
  typedef struct packed {
    logic base;
    logic rst;
  } Clock_t;
endpackage

module flash_controller
  import flash_controller_pkg::*;
#(
  parameter int unsigned READ_WAIT   = 3,
  parameter int unsigned WRITE_PULSE = 3
) (
  input  Clock_t      clk,
  input  logic [31:0] bus_address,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_mask,
  output logic        bus_stall,
  output logic [31:0] bus_data_rd,
  output logic [31:0] bus_data_rd_2,
  output logic [5:0]  bus_interrupt,
  output logic [22:0] flash_address,
  inout  wire  [15:0] flash_data,
  output logic        flash_rp_n,
  output logic        flash_vpen,
  output logic        flash_byte_n,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n
);

  localparam int unsigned CntW = 4;
  localparam logic [15:0] FLASH_OP_READ = 16'h00FF;
  localparam logic [CntW-1:0] RdLoad = CntW'(READ_WAIT - 1);
  localparam logic [CntW-1:0] WrLoad = CntW'(WRITE_PULSE - 1);

  typedef enum logic [3:0] {
    INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE,
    RD_LO, RD_HI, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  logic clk_base, rst;
  assign clk_base = clk.base;
  assign rst      = clk.rst;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [21:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [31:0]     data_rd_q, data_rd_d;
  logic [22:0]     faddr_q, faddr_d;
  logic [15:0]     dout_q, dout_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            drive_q, drive_d;
  logic            rp_n_q;
  logic            cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next state, latched request, read capture and pin values for the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_rd_d = data_rd_q;
    faddr_d   = faddr_q;
    dout_d    = dout_q;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    drive_d   = 1'b0;

    unique case (state_q)
      INIT_SETUP: if (cnt_zero) state_d = INIT_PULSE;
      INIT_PULSE: if (cnt_zero) state_d = INIT_HOLD;
      INIT_HOLD:  if (cnt_zero) state_d = IDLE;
      IDLE: begin
        if (bus_read) begin
          state_d = RD_LO;
          addr_d  = bus_address[22:1];
        end else if (bus_write) begin
          state_d = WR_SETUP;
          addr_d  = bus_address[22:1];
          wdata_d = bus_address[1] ? bus_data_wr[31:16] : bus_data_wr[15:0];
        end
      end
      RD_LO: if (cnt_zero) begin
        state_d         = RD_HI;
        data_rd_d[15:0] = flash_data;
      end
      RD_HI: if (cnt_zero) begin
        state_d          = DONE;
        data_rd_d[31:16] = flash_data;
      end
      WR_SETUP: if (cnt_zero) state_d = WR_PULSE;
      WR_PULSE: if (cnt_zero) state_d = WR_HOLD;
      WR_HOLD:  if (cnt_zero) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = INIT_SETUP;
    endcase

    // Single wait counter, reloaded whenever a new state is entered.
    if (state_d != state_q) begin
      unique case (state_d)
        RD_LO, RD_HI:         cnt_d = RdLoad;
        INIT_PULSE, WR_PULSE: cnt_d = WrLoad;
        default:              cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CntW'(1);
    end

    unique case (state_d)
      INIT_SETUP, INIT_PULSE, INIT_HOLD: begin
        faddr_d = '0;
        ce_n_d  = 1'b0;
        we_n_d  = (state_d != INIT_PULSE);
        drive_d = 1'b1;
        dout_d  = FLASH_OP_READ;
      end
      RD_LO: begin
        faddr_d = {addr_d[21:1], 2'b00};
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
      end
      RD_HI: begin
        faddr_d = {addr_d[21:1], 2'b10};
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        faddr_d = {addr_d, 1'b0};
        ce_n_d  = 1'b0;
        we_n_d  = (state_d != WR_PULSE);
        drive_d = 1'b1;
        dout_d  = wdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_base) begin
    if (rst) begin
      state_q   <= INIT_SETUP;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_rd_q <= '0;
      faddr_q   <= '0;
      dout_q    <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drive_q   <= 1'b0;
      rp_n_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_rd_q <= data_rd_d;
      faddr_q   <= faddr_d;
      dout_q    <= dout_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      drive_q   <= drive_d;
      rp_n_q    <= 1'b1;
    end
  end

  // Stall also covers reset so an abandoned request never sees a stale DONE.
  assign bus_stall     = (bus_read | bus_write) & ((state_q != DONE) | rst);
  assign bus_data_rd   = data_rd_q;
  assign bus_data_rd_2 = '0;
  assign bus_interrupt = '0;

  assign flash_address = faddr_q;
  assign flash_data    = drive_q ? dout_q : 16'bz;
  assign flash_rp_n    = rp_n_q;
  assign flash_vpen    = 1'b1;
  assign flash_byte_n  = 1'b1;
  assign flash_ce_n    = ce_n_q;
  assign flash_oe_n    = oe_n_q;
  assign flash_we_n    = we_n_q;

  logic unused_c;
  assign unused_c = ^{bus_mask, bus_address[31:23], bus_address[0]};

endmodule

// File: tb/tb_flash_controller.sv
// Self-checking bench for flash_controller: directed cases plus randomized
// transactions against a flash content model and an expected write-cycle list.
module tb_flash_controller;
  import flash_controller_pkg::*;

  localparam int unsigned READ_WAIT   = 3;
  localparam int unsigned WRITE_PULSE = 3;
  localparam int RD_LAT   = 1 + 2 * READ_WAIT;
  localparam int WR_LAT   = 3 + WRITE_PULSE;
  localparam int INIT_LEN = 2 + WRITE_PULSE;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    int          len;
  } wrec_t;

  logic        clk_base;
  logic        rst;
  Clock_t      clk;
  logic [31:0] bus_address, bus_data_wr, bus_data_rd, bus_data_rd_2;
  logic        bus_read, bus_write, bus_stall;
  logic [3:0]  bus_mask;
  logic [5:0]  bus_interrupt;
  logic [22:0] flash_address;
  wire  [15:0] flash_data;
  logic        flash_rp_n, flash_vpen, flash_byte_n, flash_ce_n, flash_oe_n, flash_we_n;

  logic [15:0] fmem [0:1023];
  wrec_t       wq[$];
  wrec_t       cur;
  bit          in_pulse, overlap, glitch;
  int          checks, errors;

  assign clk = '{base: clk_base, rst: rst};

  // Flash content depends on every address bit so misrouted high bits are visible.
  function automatic logic [15:0] fcontent(input logic [22:0] a);
    return fmem[a[10:1]] ^ {a[22:11], 4'h0};
  endfunction

  assign flash_data = (!flash_ce_n && !flash_oe_n) ? fcontent(flash_address) : 16'bz;

  flash_controller #(.READ_WAIT(READ_WAIT), .WRITE_PULSE(WRITE_PULSE)) dut (
    .clk(clk), .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_mask(bus_mask), .bus_stall(bus_stall),
    .bus_data_rd(bus_data_rd), .bus_data_rd_2(bus_data_rd_2), .bus_interrupt(bus_interrupt),
    .flash_address(flash_address), .flash_data(flash_data), .flash_rp_n(flash_rp_n),
    .flash_vpen(flash_vpen), .flash_byte_n(flash_byte_n), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  initial begin
    clk_base = 1'b0;
    forever #5 clk_base = ~clk_base;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Records each we_n low pulse (address, data, length) at the falling edge.
  task automatic monitor();
    if (!flash_we_n && !flash_oe_n) overlap = 1'b1;
    if (!flash_we_n) begin
      if (!in_pulse) begin
        cur.a = flash_address;
        cur.d = flash_data;
        cur.len = 0;
        in_pulse = 1'b1;
      end
      if (flash_address != cur.a || flash_data != cur.d || flash_ce_n) glitch = 1'b1;
      cur.len = cur.len + 1;
    end else if (in_pulse) begin
      wq.push_back(cur);
      in_pulse = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk_base);
    monitor();
    @(posedge clk_base);
    #1;
  endtask

  task automatic check_wrec(input string tag, input logic [22:0] a, input logic [15:0] d);
    wrec_t r;
    if (wq.size() > 0) begin
      r = wq.pop_front();
      check({tag, "_addr"}, 32'(r.a), 32'(a));
      check({tag, "_data"}, 32'(r.d), 32'(d));
      check({tag, "_len"}, r.len, WRITE_PULSE);
    end
  endtask

  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit scramble, input int exp_lat,
                         input int exp_init, input int rst_at);
    int n, oe_cnt, oe_rise, base_q, exp_wr;
    logic prev_oe_n;
    logic [22:0] ha;
    logic [31:0] exp_rd;
    ha = {addr[22:2], 2'b00};
    exp_rd = {fcontent(ha | 23'd2), fcontent(ha)};
    exp_wr = (wr && !rd) ? 1 : 0;
    base_q = wq.size();
    bus_read = rd;
    bus_write = wr;
    bus_address = addr;
    bus_data_wr = wdata;
    #1;
    n = 0;
    oe_cnt = 0;
    oe_rise = 0;
    prev_oe_n = 1'b1;
    while (bus_stall && n < 200) begin
      if (!flash_oe_n) oe_cnt++;
      if (flash_oe_n && !prev_oe_n) oe_rise++;
      prev_oe_n = flash_oe_n;
      tick();
      n++;
      if (scramble) begin
        bus_address = $urandom;
        bus_data_wr = $urandom;
      end
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) begin
        check("midrst_ctl", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'h7);
        check("midrst_data_rd", bus_data_rd, 32'h0);
        check("midrst_rp_n", 32'(flash_rp_n), 32'h0);
        rst = 1'b0;
      end
    end
    check("latency", n, exp_lat);
    if (rd) check("rd_data", bus_data_rd, exp_rd);
    if (rst_at < 0) begin
      check("oe_low_cycles", oe_cnt, rd ? 2 * READ_WAIT : 0);
      check("oe_rise_mid", oe_rise, 0);
    end
    check("done_ctl", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'h7);
    bus_read = 1'b0;
    bus_write = 1'b0;
    tick();
    check("wr_count", wq.size() - base_q, exp_init + exp_wr);
    for (int i = 0; i < exp_init; i++) check_wrec("init_wr", 23'd0, 16'h00FF);
    if (exp_wr != 0)
      check_wrec("bus_wr", {addr[22:1], 1'b0}, addr[1] ? wdata[31:16] : wdata[15:0]);
    wq.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_read = 1'b0;
    bus_write = 1'b0;
    bus_address = '0;
    bus_data_wr = '0;
    bus_mask = '0;
    for (int i = 0; i < 1024; i++) fmem[i] = 16'($urandom);
    fmem[10'h080] = 16'h5678;
    fmem[10'h081] = 16'h1234;

    // Reset values, then the automatic read-array command after release.
    repeat (3) tick();
    check("rst_ctl", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'h7);
    check("rst_rp_n", 32'(flash_rp_n), 32'h0);
    check("rst_vpen_byte", {30'd0, flash_vpen, flash_byte_n}, 32'h3);
    check("rst_faddr", 32'(flash_address), 32'h0);
    check("rst_data_rd", bus_data_rd, 32'h0);
    check("rst_stall_noreq", 32'(bus_stall), 32'h0);
    check("tied_zero", bus_data_rd_2 | 32'(bus_interrupt), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < INIT_LEN; c++) begin
      check("init_we_n", 32'(flash_we_n), (c >= 1 && c <= WRITE_PULSE) ? 32'h0 : 32'h1);
      check("init_rp_n", 32'(flash_rp_n), (c == 0) ? 32'h0 : 32'h1);
      tick();
    end
    check("init_wr_count", wq.size(), 1);
    check_wrec("init_wr", 23'd0, 16'h00FF);

    // Directed word read, upper-half write, and simultaneous request.
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, RD_LAT, 0, -1);
    check("word_read", bus_data_rd, 32'h1234_5678);
    run_txn(1'b0, 1'b1, 32'h0000_0202, 32'hABCD_0040, 1'b0, WR_LAT, 0, -1);
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, RD_LAT, 0, -1);
    check("both_read", bus_data_rd, 32'h1234_5678);

    // Randomized traffic, with bus address/data scrambled while stalled.
    for (int t = 0; t < 40; t++) begin
      int mode;
      logic rd, wr;
      mode = $urandom_range(0, 2);
      rd = (mode != 1);
      wr = (mode != 0);
      run_txn(rd, wr, $urandom, $urandom, 1'($urandom_range(0, 1)), rd ? RD_LAT : WR_LAT, 0, -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Request presented while reset is released: serviced once INIT is done.
    rst = 1'b1;
    bus_read = 1'b1;
    bus_address = 32'h0000_0100;
    repeat (3) tick();
    check("rst_stall_req", 32'(bus_stall), 32'h1);
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0, INIT_LEN + RD_LAT, 1, -1);

    // Reset in the second RD_HI cycle: INIT reruns and the held read is redone.
    run_txn(1'b1, 1'b0, 32'h0012_3458, 32'h0, 1'b0,
            (READ_WAIT + 2) + 1 + INIT_LEN + RD_LAT, 1, READ_WAIT + 2);

    check("no_oe_we_overlap", 32'(overlap), 32'h0);
    check("we_pulse_stable", 32'(glitch), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
